// File: rtl/ex_stage.sv
//------------------------------------------------------------------------------
// ex_stage: forwarding muxes, single-cycle ALU and iterative mult/div with HI/LO. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ex_stage #(
  parameter int MD_ITER = 32,
  parameter int PC_W    = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      alu_op,
  input  logic            alu_src,
  input  logic            reg_dst,
  input  logic [PC_W-1:0] pc_next,
  input  logic [31:0]     data1,
  input  logic [31:0]     data2,
  input  logic [31:0]     sign_extend,
  input  logic [4:0]      rt,
  input  logic [4:0]      rd,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [31:0]     mem_fwd,
  input  logic [31:0]     wb_fwd,
  input  logic            flush,
  output logic [31:0]     alu_result,
  output logic            zero,
  output logic [4:0]      write_reg,
  output logic [31:0]     store_data,
  output logic [PC_W-1:0] branch_target,
  output logic            stall,
  output logic            md_busy
);

  localparam int CNT_W = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MD_ITER - 1);

  localparam logic [5:0] OP_SLL   = 6'h00;
  localparam logic [5:0] OP_SRL   = 6'h02;
  localparam logic [5:0] OP_SRA   = 6'h03;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_SUB   = 6'h22;
  localparam logic [5:0] OP_AND   = 6'h24;
  localparam logic [5:0] OP_OR    = 6'h25;
  localparam logic [5:0] OP_XOR   = 6'h26;
  localparam logic [5:0] OP_NOR   = 6'h27;
  localparam logic [5:0] OP_SLT   = 6'h2A;
  localparam logic [5:0] OP_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      b_q, b_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             neg_r_q, neg_r_d;
  logic             div0_q, div0_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0] op_a, fwd_b_val, op_b;
  logic [4:0]  shamt;

  always_comb begin
    case (fwd_a)
      2'b01:   op_a = mem_fwd;
      2'b10:   op_a = wb_fwd;
      default: op_a = data1;
    endcase
    case (fwd_b)
      2'b01:   fwd_b_val = mem_fwd;
      2'b10:   fwd_b_val = wb_fwd;
      default: fwd_b_val = data2;
    endcase
  end

  assign op_b          = alu_src ? sign_extend : fwd_b_val;
  assign shamt         = sign_extend[10:6];
  assign store_data    = fwd_b_val;
  assign write_reg     = reg_dst ? rd : rt;
  assign branch_target = pc_next + sign_extend[PC_W-1:0];
  assign zero          = (alu_result == 32'd0);
  assign md_busy       = (state_q != IDLE);

  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_NOR:  alu_result = ~(op_a | op_b);
      OP_SLT:  alu_result = {31'd0, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_result = {31'd0, (op_a < op_b)};
      OP_SLL:  alu_result = op_b << shamt;
      OP_SRL:  alu_result = op_b >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(op_b) >>> shamt);
      OP_LUI:  alu_result = {op_b[15:0], 16'd0};
      OP_MFHI: alu_result = hi_q;
      OP_MFLO: alu_result = lo_q;
      default: alu_result = 32'd0;
    endcase
  end

  // Engine works on magnitudes: acc low half holds multiplier/dividend, high half the partial result.
  logic        is_md, is_signed, sa, sb;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, div_next, step, prod_fix;
  logic [33:0] div_diff;
  logic        div_ok;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    is_md     = (alu_op == OP_MULT) || (alu_op == OP_MULTU) ||
                (alu_op == OP_DIV)  || (alu_op == OP_DIVU);
    is_signed = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    sa        = is_signed & op_a[31];
    sb        = is_signed & op_b[31];
    abs_a     = sa ? -op_a : op_a;
    abs_b     = sb ? -op_b : op_b;

    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    div_diff = {1'b0, acc_q[63:31]} - {2'b00, b_q};
    div_ok   = ~div_diff[33];
    div_next = {(div_ok ? div_diff[31:0] : acc_q[62:31]), acc_q[30:0], div_ok};
    step     = is_div_q ? div_next : mul_next;

    prod_fix = neg_q ? -step : step;
    quo_fix  = div0_q ? 32'hFFFF_FFFF : (neg_q ? -step[31:0] : step[31:0]);
    rem_fix  = neg_r_q ? -step[63:32] : step[63:32];
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_md && !flush) begin
          stall    = 1'b1;
          state_d  = BUSY;
          count_d  = '0;
          acc_d    = {32'd0, abs_a};
          b_d      = abs_b;
          is_div_d = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
          neg_d    = sa ^ sb;
          neg_r_d  = sa;
          div0_d   = (op_b == 32'd0);
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d   = step;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            state_d = DONE;
            if (is_div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              hi_d = prod_fix[63:32];
              lo_d = prod_fix[31:0];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= 64'd0;
      b_q      <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
//------------------------------------------------------------------------------
// tb_ex_stage: directed self-checking bench for ex_stage. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  alu_op;
  logic        alu_src, reg_dst, flush;
  logic [6:0]  pc_next;
  logic [31:0] data1, data2, sign_extend, mem_fwd, wb_fwd;
  logic [4:0]  rt, rd;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] alu_result, store_data;
  logic        zero, stall, md_busy;
  logic [4:0]  write_reg;
  logic [6:0]  branch_target;

  int checks = 0;
  int errors = 0;

  ex_stage #(.MD_ITER(32), .PC_W(7)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
    .pc_next(pc_next), .data1(data1), .data2(data2), .sign_extend(sign_extend),
    .rt(rt), .rd(rd), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
    .flush(flush), .alu_result(alu_result), .zero(zero), .write_reg(write_reg),
    .store_data(store_data), .branch_target(branch_target), .stall(stall), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a mult/div, count stall cycles, then read HI/LO in DONE and once more after.
  task automatic run_md(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    alu_op = op; data1 = a; data2 = b; alu_src = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    check({tag, " stall_cycles"}, 64'(n), 64'd33);
    check({tag, " busy_in_done"}, {63'd0, md_busy}, 64'd1);
    alu_op = 6'h10; #1;
    check({tag, " hi"}, {32'd0, alu_result}, {32'd0, ehi});
    alu_op = 6'h12; #1;
    check({tag, " lo"}, {32'd0, alu_result}, {32'd0, elo});
    tick();
    check({tag, " lo_after"}, {32'd0, alu_result}, {32'd0, elo});
    check({tag, " idle_after"}, {62'd0, md_busy, stall}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; alu_op = 6'h00; alu_src = 1'b0; reg_dst = 1'b0; flush = 1'b0;
    pc_next = 7'd0; data1 = 32'd0; data2 = 32'd0; sign_extend = 32'd0;
    mem_fwd = 32'd0; wb_fwd = 32'd0; rt = 5'd0; rd = 5'd0; fwd_a = 2'b00; fwd_b = 2'b00;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset alu_result", {32'd0, alu_result}, 64'd0);
    check("reset zero", {63'd0, zero}, 64'd1);
    check("reset stall_busy", {62'd0, stall, md_busy}, 64'd0);
    alu_op = 6'h10; #1;
    check("reset hi", {32'd0, alu_result}, 64'd0);

    alu_op = 6'h20; data1 = 32'd7; sign_extend = 32'd5; alu_src = 1'b1; #1;
    check("add", {32'd0, alu_result}, 64'd12);
    check("add zero", {63'd0, zero}, 64'd0);
    alu_op = 6'h22; data1 = 32'd5; #1;
    check("sub zero", {63'd0, zero}, 64'd1);
    alu_op = 6'h2A; data1 = 32'hFFFF_FFFF; sign_extend = 32'd1; #1;
    check("slt", {32'd0, alu_result}, 64'd1);
    alu_op = 6'h2B; #1;
    check("sltu", {32'd0, alu_result}, 64'd0);

    alu_op = 6'h20; alu_src = 1'b0; fwd_a = 2'b01; mem_fwd = 32'h10; fwd_b = 2'b10; wb_fwd = 32'h3; #1;
    check("fwd add", {32'd0, alu_result}, 64'h13);
    alu_src = 1'b1; sign_extend = 32'd0; #1;
    check("store_data", {32'd0, store_data}, 64'h3);
    fwd_a = 2'b00; fwd_b = 2'b00;

    alu_op = 6'h00; alu_src = 1'b0; data2 = 32'd1; sign_extend = 32'h100; #1;
    check("sll", {32'd0, alu_result}, 64'h10);
    alu_op = 6'h03; data2 = 32'h8000_0000; #1;
    check("sra", {32'd0, alu_result}, 64'hF800_0000);
    alu_op = 6'h0F; alu_src = 1'b1; sign_extend = 32'h1234; #1;
    check("lui", {32'd0, alu_result}, 64'h1234_0000);
    alu_op = 6'h3F; #1;
    check("undef op", {32'd0, alu_result}, 64'd0);
    reg_dst = 1'b1; rd = 5'd9; rt = 5'd4; pc_next = 7'h7F; sign_extend = 32'd2; #1;
    check("write_reg rd", {59'd0, write_reg}, 64'd9);
    check("branch wrap", {57'd0, branch_target}, 64'd1);
    reg_dst = 1'b0; #1;
    check("write_reg rt", {59'd0, write_reg}, 64'd4);

    run_md("mult", 6'h18, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_md("div", 6'h1A, 32'd17, 32'hFFFF_FFFB, 32'd2, 32'hFFFF_FFFD);
    run_md("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_md("multu1", 6'h19, 32'd2, 32'd3, 32'd0, 32'd6);
    run_md("multu2", 6'h19, 32'd4, 32'd5, 32'd0, 32'd20);

    alu_op = 6'h19; data1 = 32'hFFFF_FFFF; data2 = 32'hFFFF_FFFF;
    tick();
    repeat (10) tick();
    check("flush pre stall", {63'd0, stall}, 64'd1);
    flush = 1'b1; alu_op = 6'h00;
    tick();
    flush = 1'b0; #1;
    check("flush stall_busy", {62'd0, stall, md_busy}, 64'd0);
    alu_op = 6'h10; #1;
    check("flush hi", {32'd0, alu_result}, 64'd0);
    alu_op = 6'h12; #1;
    check("flush lo", {32'd0, alu_result}, 64'd20);

    run_md("divu0", 6'h1B, 32'd10, 32'd0, 32'd10, 32'hFFFF_FFFF);

    alu_op = 6'h18; data1 = 32'd5; data2 = 32'd5;
    repeat (6) tick();
    rst = 1'b1; alu_op = 6'h00;
    tick();
    rst = 1'b0; #1;
    check("rst mid stall_busy", {62'd0, stall, md_busy}, 64'd0);
    alu_op = 6'h10; #1;
    check("rst mid hi", {32'd0, alu_result}, 64'd0);
    alu_op = 6'h12; #1;
    check("rst mid lo", {32'd0, alu_result}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
